vpe_kernel_array_sched: RTL and testbench

// - Parametrised scheduler feeding NUM_KERNELS VPE kernel instances from one packet-feature stream.
// - Returns inference results in strict arrival order over a valid/ready egress.
// - Sits between the feature extractor and a bank of VPE kernels.
// - Adds three capabilities a single kernel lacks: multi-kernel parallelism, upstream backpressure, and in-order reassembly.

---
 rtl/vpe_kernel_array_sched.sv | 173 +++++++++++++++++
 tb/tb_vpe_kernel_array_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vpe_kernel_array_sched.sv
// Round-robin dispatcher for NUM_KERNELS VPE kernels with in-order result reassembly.
// Optional sequence tagging of results is enabled by defining VPE_SCHED_SEQ_EN.
module vpe_kernel_array_sched #(
  parameter int NUM_KERNELS = 4,
  parameter int DATA_W      = 256,
  parameter int SEQ_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_feat_valid,
  output logic                          s_feat_ready,
  input  logic [DATA_W-1:0]             s_feat_data,
  input  logic [NUM_KERNELS-1:0]        k_fetch,
  output logic [NUM_KERNELS-1:0]        k_feat_valid,
  output logic [DATA_W-1:0]             k_feat_data,
  input  logic [NUM_KERNELS-1:0]        k_res_valid,
  input  logic [NUM_KERNELS*DATA_W-1:0] k_res_data,
  output logic                          m_res_valid,
  input  logic                          m_res_ready,
  output logic [DATA_W-1:0]             m_res_data,
`ifdef VPE_SCHED_SEQ_EN
  output logic [SEQ_W-1:0]              m_res_seq,
`endif
  output logic [$clog2(NUM_KERNELS+1)-1:0] inflight_cnt,
  output logic                          proto_err,
  output logic [2*NUM_KERNELS-1:0]      kernel_state
);

  localparam int IDX_W = $clog2(NUM_KERNELS);
  localparam int CNT_W = $clog2(NUM_KERNELS+1);
  localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(NUM_KERNELS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_KERNELS-1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } kstate_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready and is held (with its data) until accepted.
  kstate_t                state_q   [NUM_KERNELS];
  kstate_t                state_d   [NUM_KERNELS];
  logic [NUM_KERNELS-1:0] res_capture;
  logic [NUM_KERNELS-1:0] eligible;
  logic [NUM_KERNELS-1:0] not_busy;
  logic [DATA_W-1:0]      res_buf   [NUM_KERNELS];
  logic [IDX_W-1:0]       fifo_mem  [NUM_KERNELS];
  logic [IDX_W-1:0]       rd_ptr, wr_ptr, rr_ptr, sel, head;
  logic [IDX_W:0]         cand;
  logic [CNT_W-1:0]       fifo_cnt;
  logic                   sel_found, accept, pop;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == LAST) ? '0 : x + 1'b1;
  endfunction

  assign head   = fifo_mem[rd_ptr];
  assign accept = s_feat_valid && s_feat_ready;
  assign pop    = m_res_valid && m_res_ready;

  // Round-robin pick: first eligible kernel at or after rr_ptr.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_KERNELS; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!sel_found && eligible[cand[IDX_W-1:0]]) begin
        sel       = cand[IDX_W-1:0];
        sel_found = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_KERNELS; k++) state_q[k] <= ST_IDLE;
    end else begin
      for (int k = 0; k < NUM_KERNELS; k++) state_q[k] <= state_d[k];
    end
  end

  // FSM next state; accept, capture and pop touch different kernels so they never collide
  always_comb begin
    res_capture = '0;
    for (int k = 0; k < NUM_KERNELS; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        ST_IDLE: if (accept && sel == IDX_W'(k)) state_d[k] = ST_BUSY;
        ST_BUSY: if (k_res_valid[k]) begin
          state_d[k]     = ST_DONE;
          res_capture[k] = 1'b1;
        end
        ST_DONE: if (pop && head == IDX_W'(k)) state_d[k] = ST_IDLE;
        default: state_d[k] = ST_IDLE;
      endcase
    end
  end

  // FSM-derived outputs, all from registered state
  always_comb begin
    eligible     = '0;
    not_busy     = '0;
    inflight_cnt = '0;
    kernel_state = '0;
    for (int k = 0; k < NUM_KERNELS; k++) begin
      eligible[k]            = k_fetch[k] && (state_q[k] == ST_IDLE);
      not_busy[k]            = (state_q[k] != ST_BUSY);
      inflight_cnt           = inflight_cnt + CNT_W'(state_q[k] != ST_IDLE);
      kernel_state[2*k +: 2] = state_q[k];
    end
    s_feat_ready = |eligible;
    m_res_valid  = (fifo_cnt != '0) && (state_q[head] == ST_DONE);
    m_res_data   = res_buf[head];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_KERNELS; k++) begin
        res_buf[k]  <= '0;
        fifo_mem[k] <= '0;
      end
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      rr_ptr       <= '0;
      fifo_cnt     <= '0;
      k_feat_valid <= '0;
      k_feat_data  <= '0;
      proto_err    <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_KERNELS; k++) begin
        if (res_capture[k]) res_buf[k] <= k_res_data[k*DATA_W +: DATA_W];
      end
      k_feat_valid <= accept ? (NUM_KERNELS'(1) << sel) : '0;
      if (accept) begin
        k_feat_data      <= s_feat_data;
        fifo_mem[wr_ptr] <= sel;
        wr_ptr           <= wrap_inc(wr_ptr);
        rr_ptr           <= wrap_inc(sel);
      end
      if (pop) rd_ptr <= wrap_inc(rd_ptr);
      case ({accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (|(k_res_valid & not_busy)) proto_err <= 1'b1;
    end
  end

`ifdef VPE_SCHED_SEQ_EN
  logic [SEQ_W-1:0] seq_cnt;
  logic [SEQ_W-1:0] seq_buf [NUM_KERNELS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt <= '0;
      for (int k = 0; k < NUM_KERNELS; k++) seq_buf[k] <= '0;
    end else if (accept) begin
      seq_cnt      <= seq_cnt + 1'b1;
      seq_buf[sel] <= seq_cnt;
    end
  end

  assign m_res_seq = seq_buf[head];
`else
  localparam int unused_seq_w = SEQ_W;
`endif

endmodule

// File: tb/tb_vpe_kernel_array_sched.sv
// Directed bench for vpe_kernel_array_sched (4 kernels, 256-bit words); honours VPE_SCHED_SEQ_EN.
module tb_vpe_kernel_array_sched;

  localparam int NK = 4;
  localparam int DW = 256;
  localparam int SW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_feat_valid = 1'b0;
  logic            s_feat_ready;
  logic [DW-1:0]   s_feat_data = '0;
  logic [NK-1:0]   k_fetch = '0;
  logic [NK-1:0]   k_feat_valid;
  logic [DW-1:0]   k_feat_data;
  logic [NK-1:0]   k_res_valid = '0;
  logic [NK*DW-1:0] k_res_data = '0;
  logic            m_res_valid;
  logic            m_res_ready = 1'b0;
  logic [DW-1:0]   m_res_data;
  logic [SW-1:0]   m_res_seq;
  logic [2:0]      inflight_cnt;
  logic            proto_err;
  logic [2*NK-1:0] kernel_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [SW-1:0] exp_seq_q[$];
  logic [DW-1:0] res_word [NK];
  logic [DW-1:0] held;

  vpe_kernel_array_sched #(.NUM_KERNELS(NK), .DATA_W(DW), .SEQ_W(SW)) dut (
    .clk(clk), .rst(rst),
    .s_feat_valid(s_feat_valid), .s_feat_ready(s_feat_ready), .s_feat_data(s_feat_data),
    .k_fetch(k_fetch), .k_feat_valid(k_feat_valid), .k_feat_data(k_feat_data),
    .k_res_valid(k_res_valid), .k_res_data(k_res_data),
    .m_res_valid(m_res_valid), .m_res_ready(m_res_ready), .m_res_data(m_res_data),
`ifdef VPE_SCHED_SEQ_EN
    .m_res_seq(m_res_seq),
`endif
    .inflight_cnt(inflight_cnt), .proto_err(proto_err), .kernel_state(kernel_state)
  );

`ifndef VPE_SCHED_SEQ_EN
  assign m_res_seq = '0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_feat(input logic [DW-1:0] d);
    int n;
    n = 0;
    s_feat_valid = 1'b1;
    s_feat_data  = d;
    #1;
    while (!s_feat_ready && n < 20) begin
      tick();
      n++;
    end
    check("feat_ready_wait", 256'(n < 20), 256'd1);
    tick();
    s_feat_valid = 1'b0;
  endtask

  task automatic give_res(input int k, input logic [DW-1:0] d);
    k_res_data[k*DW +: DW] = d;
    k_res_valid = NK'(1) << k;
    tick();
    k_res_valid = '0;
  endtask

  initial begin
    for (int k = 0; k < NK; k++) res_word[k] = {8{32'hC0DE_0000 + 32'(k)}};
    do_reset();

    // reset state
    check("rst_ready",    256'(s_feat_ready), 256'd0);
    check("rst_m_valid",  256'(m_res_valid), 256'd0);
    check("rst_inflight", 256'(inflight_cnt), 256'd0);
    check("rst_kvalid",   256'(k_feat_valid), 256'd0);
    check("rst_kdata",    k_feat_data, 256'd0);
    check("rst_proto",    256'(proto_err), 256'd0);

    // single feature: 1-cycle dispatch, result appears the cycle after capture
    k_fetch = 4'hF;
    send_feat({32{8'hA5}});
    check("t1_kvalid",   256'(k_feat_valid), 256'h1);
    check("t1_kdata",    k_feat_data, {32{8'hA5}});
    check("t1_inflight", 256'(inflight_cnt), 256'd1);
    tick();
    check("t1_kvalid_pulse", 256'(k_feat_valid), 256'h0);
    check("t1_kdata_hold",   k_feat_data, {32{8'hA5}});
    give_res(0, res_word[0]);
    check("t1_m_valid", 256'(m_res_valid), 256'd1);
    check("t1_m_data",  m_res_data, res_word[0]);
    m_res_ready = 1'b1;
    tick();
    m_res_ready = 1'b0;
    check("t1_popped",   256'(m_res_valid), 256'd0);
    check("t1_inflight0", 256'(inflight_cnt), 256'd0);

    // four back-to-back features, results return 3,1,0,2
    do_reset();
    for (int i = 0; i < NK; i++) begin
      send_feat({8{32'hFEA7_0000 + 32'(i)}});
      check("t2_dispatch", 256'(k_feat_valid), 256'(NK'(1) << i));
      exp_q.push_back(res_word[i]);
      exp_seq_q.push_back(SW'(i));
    end
    check("t2_full_ready", 256'(s_feat_ready), 256'd0);
    check("t2_inflight4",  256'(inflight_cnt), 256'd4);
    give_res(3, res_word[3]);
    check("t2_wait_after3", 256'(m_res_valid), 256'd0);
    give_res(1, res_word[1]);
    check("t2_wait_after1", 256'(m_res_valid), 256'd0);
    give_res(0, res_word[0]);
    check("t2_head_ready", 256'(m_res_valid), 256'd1);
    give_res(2, res_word[2]);

    // egress stalled 10 cycles with all kernels DONE
    held = m_res_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_stall_data", m_res_data, held);
    end
    check("t3_stall_valid",    256'(m_res_valid), 256'd1);
    check("t3_stall_inflight", 256'(inflight_cnt), 256'd4);
    check("t3_stall_ready",    256'(s_feat_ready), 256'd0);

    // release: four pops in four cycles, arrival order
    m_res_ready = 1'b1;
    for (int i = 0; i < NK; i++) begin
      logic [DW-1:0] e;
      logic [SW-1:0] es;
      e  = exp_q.pop_front();
      es = exp_seq_q.pop_front();
      check("t3_pop_valid", 256'(m_res_valid), 256'd1);
      check("t3_pop_data",  m_res_data, e);
`ifdef VPE_SCHED_SEQ_EN
      check("t3_pop_seq",   256'(m_res_seq), 256'(es));
`endif
      if (i == 1) check("t3_ready_after_pop", 256'(s_feat_ready), 256'd1);
      tick();
    end
    m_res_ready = 1'b0;
    check("t3_drained",   256'(m_res_valid), 256'd0);
    check("t3_inflight0", 256'(inflight_cnt), 256'd0);

    // result pulse from an idle kernel
    check("t5_proto_before", 256'(proto_err), 256'd0);
    give_res(2, {8{32'hDEAD_BEEF}});
    check("t5_proto_set",   256'(proto_err), 256'd1);
    check("t5_no_egress",   256'(m_res_valid), 256'd0);
    check("t5_state_idle",  256'(kernel_state), 256'd0);
    tick();
    check("t5_proto_sticky", 256'(proto_err), 256'd1);

    // async reset with kernels 0,2 BUSY and kernel 1 DONE
    for (int i = 0; i < 3; i++) send_feat({8{32'h5EED_0000 + 32'(i)}});
    give_res(1, res_word[1]);
    check("t6_pre_inflight", 256'(inflight_cnt), 256'd3);
    check("t6_pre_state",    256'(kernel_state), 256'b00_01_10_01);
    check("t6_pre_kdata",    k_feat_data, {8{32'h5EED_0002}});
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_inflight", 256'(inflight_cnt), 256'd0);
    check("t6_rst_m_valid",  256'(m_res_valid), 256'd0);
    check("t6_rst_m_data",   m_res_data, 256'd0);
    check("t6_rst_kvalid",   256'(k_feat_valid), 256'd0);
    check("t6_rst_kdata",    k_feat_data, 256'd0);
    check("t6_rst_proto",    256'(proto_err), 256'd0);
    tick();
    rst = 1'b0;
    send_feat({8{32'h0000_ABCD}});
    check("t6_first_kernel0", 256'(k_feat_valid), 256'h1);
    give_res(0, res_word[2]);
    check("t6_result", m_res_data, res_word[2]);
`ifdef VPE_SCHED_SEQ_EN
    check("t6_seq0", 256'(m_res_seq), 256'd0);
`endif

    // pop of kernel 0 frees it only for the following cycle
    do_reset();
    k_fetch = 4'h1;
    send_feat({8{32'h1111_1111}});
    give_res(0, res_word[0]);
    s_feat_valid = 1'b1;
    s_feat_data  = {8{32'h2222_2222}};
    m_res_ready  = 1'b1;
    #1;
    check("t4_ready_before_pop", 256'(s_feat_ready), 256'd0);
    check("t4_valid_before_pop", 256'(m_res_valid), 256'd1);
    tick();
    m_res_ready = 1'b0;
    check("t4_no_same_cycle", 256'(k_feat_valid), 256'h0);
    check("t4_ready_after",   256'(s_feat_ready), 256'd1);
    check("t4_popped",        256'(m_res_valid), 256'd0);
    tick();
    s_feat_valid = 1'b0;
    check("t4_accept_next", 256'(k_feat_valid), 256'h1);
    check("t4_kdata",       k_feat_data, {8{32'h2222_2222}});
    check("t4_inflight",    256'(inflight_cnt), 256'd1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
